// File: rtl/dpp_pkg.sv
// Shared definitions for the dining-philosophers design: state and event
// encodings, boolean constants and the default timer width.
package dpp_pkg;

  typedef logic [1:0] philo_state_t;

  localparam philo_state_t ST_THINKING   = 2'd0;
  localparam philo_state_t ST_HUNGRY     = 2'd1;
  localparam philo_state_t ST_GRANT_WAIT = 2'd2;
  localparam philo_state_t ST_EATING     = 2'd3;

  localparam logic EV_HUNGRY = 1'b1;
  localparam logic EV_DONE   = 1'b0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DPP_TIMER_SIZE = 2;

  // The timer only runs while thinking or eating.
  function automatic logic is_timed_state(input philo_state_t s);
    return (s == ST_THINKING) || (s == ST_EATING);
  endfunction

endpackage

// File: rtl/philo_timer.sv
// Loadable down-counter for think/eat durations; saturates at zero and
// reports expiry while the count is zero.
module philo_timer
  import dpp_pkg::*;
#(
  parameter int                    TIMER_SIZE = DPP_TIMER_SIZE,
  parameter logic [TIMER_SIZE-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [TIMER_SIZE-1:0] load_val,
  input  logic                  en,
  output logic                  expired
);

  logic [TIMER_SIZE-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIMER_SIZE'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/philosopher_fsm.sv
// Per-seat philosopher controller: think, request a grant, eat, report done.
// Optional meal counter enabled by defining PHILO_MEAL_COUNT_EN.
//
// state         | meaning
// ST_THINKING   | think timer running; emit HUNGRY on expiry
// ST_HUNGRY     | waiting for a grant entry in fin
// ST_GRANT_WAIT | read issued; sample fin_dout
// ST_EATING     | eat timer running; emit DONE on expiry
module philosopher_fsm
  import dpp_pkg::*;
#(
  parameter int TIMER_SIZE  = DPP_TIMER_SIZE,
  parameter int THINK_TICKS = 3,
  parameter int EAT_TICKS   = 2
`ifdef PHILO_MEAL_COUNT_EN
  ,parameter int MEAL_W     = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fin_dout,
  input  logic       fin_empty,
  output logic       fin_rden,
  output logic       fout_din,
  output logic       fout_wren,
  input  logic       fout_full,
  output logic [1:0] state
`ifdef PHILO_MEAL_COUNT_EN
  ,output logic [MEAL_W-1:0] meals
`endif
);

  localparam logic [TIMER_SIZE-1:0] THINK_LOAD = TIMER_SIZE'(THINK_TICKS);
  localparam logic [TIMER_SIZE-1:0] EAT_LOAD   = TIMER_SIZE'(EAT_TICKS);

  logic                  expired;
  logic                  think_fire;
  logic                  eat_fire;
  logic                  grant_ok;
  logic                  timer_load;
  logic [TIMER_SIZE-1:0] timer_load_val;

  // Gating on the previous strobe keeps write pulses apart even with zero ticks.
  assign think_fire = (state == ST_THINKING) && expired && !fout_full && !fout_wren;
  assign eat_fire   = (state == ST_EATING)   && expired && !fout_full && !fout_wren;
  assign grant_ok   = (state == ST_GRANT_WAIT) && fin_dout;

  assign timer_load     = grant_ok || eat_fire;
  assign timer_load_val = eat_fire ? THINK_LOAD : EAT_LOAD;

  philo_timer #(
    .TIMER_SIZE (TIMER_SIZE),
    .RST_VAL    (THINK_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (is_timed_state(state)),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_THINKING;
      fin_rden  <= FALSE;
      fout_wren <= FALSE;
      fout_din  <= EV_DONE;
    end else begin
      fin_rden  <= FALSE;
      fout_wren <= FALSE;
      case (state)
        ST_THINKING: begin
          if (think_fire) begin
            fout_wren <= TRUE;
            fout_din  <= EV_HUNGRY;
            state     <= ST_HUNGRY;
          end
        end
        ST_HUNGRY: begin
          if (!fin_empty && !fin_rden) begin
            fin_rden <= TRUE;
            state    <= ST_GRANT_WAIT;
          end
        end
        ST_GRANT_WAIT: begin
          state <= fin_dout ? ST_EATING : ST_HUNGRY;
        end
        ST_EATING: begin
          if (eat_fire) begin
            fout_wren <= TRUE;
            fout_din  <= EV_DONE;
            state     <= ST_THINKING;
          end
        end
        default: state <= ST_THINKING;
      endcase
    end
  end

`ifdef PHILO_MEAL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      meals <= '0;
    end else if (eat_fire) begin
      meals <= meals + MEAL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_philosopher_fsm.sv
// Bench for philosopher_fsm: directed scenarios plus random traffic against a
// phase/elapsed-time reference model. Define PHILO_MEAL_COUNT_EN to cover meals.
module tb_philosopher_fsm;

  localparam int THINK = 3;
  localparam int EAT   = 2;
`ifdef PHILO_MEAL_COUNT_EN
  localparam int MEAL_W = 2;
`else
  localparam int MEAL_W = 8;
`endif
  localparam int MEAL_MOD = 1 << MEAL_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fin_dout = 1'b0;
  logic       fin_empty = 1'b1;
  logic       fin_rden;
  logic       fout_din;
  logic       fout_wren;
  logic       fout_full = 1'b0;
  logic [1:0] state;
`ifdef PHILO_MEAL_COUNT_EN
  logic [MEAL_W-1:0] meals;
`endif

  philosopher_fsm #(
    .TIMER_SIZE  (2),
    .THINK_TICKS (THINK),
    .EAT_TICKS   (EAT)
`ifdef PHILO_MEAL_COUNT_EN
    ,.MEAL_W     (MEAL_W)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fin_dout  (fin_dout),
    .fin_empty (fin_empty),
    .fin_rden  (fin_rden),
    .fout_din  (fout_din),
    .fout_wren (fout_wren),
    .fout_full (fout_full),
    .state     (state)
`ifdef PHILO_MEAL_COUNT_EN
    ,.meals    (meals)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   ev_hungry = 0;
  int   ev_done = 0;
  logic fin_q[$];

  // Reference model: phase number (as reported on state), cycles spent in it.
  int   m_ph = 0;
  int   m_el = 0;
  logic m_w = 1'b0;
  logic m_r = 1'b0;
  logic m_d = 1'b0;
  int   m_meals = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic emp, input logic dv, input logic full);
    int  nph;
    logic nw, nr;
    if (!rst) begin
      m_ph = 0; m_el = 0; m_w = 0; m_r = 0; m_d = 0; m_meals = 0;
    end else begin
      nph = m_ph; nw = 0; nr = 0;
      case (m_ph)
        0: if (m_el >= THINK && !full && !m_w) begin nw = 1; m_d = 1; nph = 1; end
        1: if (!emp && !m_r) begin nr = 1; nph = 2; end
        2: nph = dv ? 3 : 1;
        default: if (m_el >= EAT && !full && !m_w) begin
          nw = 1; m_d = 0; nph = 0; m_meals = (m_meals + 1) % MEAL_MOD;
        end
      endcase
      m_el = (nph != m_ph) ? 0 : m_el + 1;
      m_ph = nph; m_w = nw; m_r = nr;
    end
  endtask

  task automatic step(input logic rst, input logic full);
    logic emp, dv, rd;
    emp = (fin_q.size() == 0);
    dv  = emp ? 1'b0 : fin_q[0];
    reset = rst; fout_full = full; fin_empty = emp; fin_dout = dv;
    rd = fin_rden;
    model_step(rst, emp, dv, full);
    @(posedge clk); #1;
    if (rd && !emp) void'(fin_q.pop_front());
    if (fout_wren === 1'b1 && fout_din === 1'b1) ev_hungry++;
    if (fout_wren === 1'b1 && fout_din === 1'b0) ev_done++;
    check("state", 8'(state), 8'(m_ph));
    check("fout_wren", 8'(fout_wren), 8'(m_w));
    check("fout_din", 8'(fout_din), 8'(m_d));
    check("fin_rden", 8'(fin_rden), 8'(m_r));
    check("one_strobe", 8'(fin_rden & fout_wren), 8'd0);
`ifdef PHILO_MEAL_COUNT_EN
    check("meals", 8'(meals), 8'(m_meals));
`endif
  endtask

  task automatic wait_state(input logic [1:0] target, input int max_cycles);
    int n;
    n = 0;
    while (state !== target && n < max_cycles) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("wait_state_timeout", 8'(state), 8'(target));
  endtask

`ifdef PHILO_MEAL_COUNT_EN
  int meal_exp [5] = '{1, 2, 3, 0, 1};
`endif

  initial begin
    // Reset held two cycles
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_state", 8'(state), 8'd0);
    check("rst_rden", 8'(fin_rden), 8'd0);
    check("rst_wren", 8'(fout_wren), 8'd0);
`ifdef PHILO_MEAL_COUNT_EN
    check("rst_meals", 8'(meals), 8'd0);
`endif

    // HUNGRY write exactly THINK+1 cycles after release
    for (int i = 1; i <= THINK; i++) begin
      step(1'b1, 1'b0);
      check("think_early_wren", 8'(fout_wren), 8'd0);
    end
    step(1'b1, 1'b0);
    check("think_wren", 8'(fout_wren), 8'd1);
    check("think_din", 8'(fout_din), 8'd1);
    check("think_state", 8'(state), 8'd1);

    // Full meal
    fin_q.push_back(1'b1);
    step(1'b1, 1'b0);
    check("meal_rden", 8'(fin_rden), 8'd1);
    check("meal_gw", 8'(state), 8'd2);
    step(1'b1, 1'b0);
    check("meal_eat", 8'(state), 8'd3);
    check("meal_rden_once", 8'(fin_rden), 8'd0);
    for (int i = 1; i <= EAT; i++) begin
      step(1'b1, 1'b0);
      check("eat_early_wren", 8'(fout_wren), 8'd0);
    end
    step(1'b1, 1'b0);
    check("done_wren", 8'(fout_wren), 8'd1);
    check("done_din", 8'(fout_din), 8'd0);
    check("done_state", 8'(state), 8'd0);
`ifdef PHILO_MEAL_COUNT_EN
    check("done_meals", 8'(meals), 8'd1);
`endif

    // Denial then grant
    ev_hungry = 0;
    wait_state(2'd1, 20);
    fin_q.push_back(1'b0);
    fin_q.push_back(1'b1);
    step(1'b1, 1'b0);
    check("deny_gw1", 8'(state), 8'd2);
    check("deny_rden1", 8'(fin_rden), 8'd1);
    step(1'b1, 1'b0);
    check("deny_back", 8'(state), 8'd1);
    step(1'b1, 1'b0);
    check("deny_gw2", 8'(state), 8'd2);
    check("deny_rden2", 8'(fin_rden), 8'd1);
    step(1'b1, 1'b0);
    check("deny_eat", 8'(state), 8'd3);
    check("deny_one_hungry", 8'(ev_hungry), 8'd1);

    // Backpressure at eat expiry
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      check("bp_state", 8'(state), 8'd3);
      check("bp_wren", 8'(fout_wren), 8'd0);
    end
    step(1'b1, 1'b0);
    check("bp_release_wren", 8'(fout_wren), 8'd1);
    check("bp_release_din", 8'(fout_din), 8'd0);

    // Reset during EATING
    wait_state(2'd1, 20);
    fin_q.push_back(1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_eating", 8'(state), 8'd3);
    ev_done = 0;
    step(1'b0, 1'b0);
    check("mid_rst_state", 8'(state), 8'd0);
    check("mid_rst_wren", 8'(fout_wren), 8'd0);
`ifdef PHILO_MEAL_COUNT_EN
    check("mid_rst_meals", 8'(meals), 8'd0);
`endif
    for (int i = 0; i < THINK; i++) step(1'b1, 1'b0);
    check("mid_no_done", 8'(ev_done), 8'd0);
    check("mid_think_early", 8'(fout_wren), 8'd0);
    step(1'b1, 1'b0);
    check("mid_think_wren", 8'(fout_wren), 8'd1);

    // Five meals, meal counter wraps at MEAL_W bits
    for (int k = 0; k < 5; k++) begin
      int n;
      fin_q.push_back(1'b1);
      n = 0;
      step(1'b1, 1'b0);
      while (!(fout_wren === 1'b1 && fout_din === 1'b0) && n < 40) begin
        step(1'b1, 1'b0);
        n++;
      end
      check("meal_loop_done", 8'(fout_wren & ~fout_din), 8'd1);
`ifdef PHILO_MEAL_COUNT_EN
      check("meal_seq", 8'(meals), 8'(meal_exp[k]));
`endif
    end

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic r, f;
      r = ($urandom_range(99) != 0);
      f = ($urandom_range(3) == 0);
      if ($urandom_range(2) == 0 && fin_q.size() < 4) fin_q.push_back(1'($urandom_range(1)));
      step(r, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
